// File: rtl/led_pattern_engine.sv
// -----------------------------------------------------------------------------
// led_pattern_engine
//   Button-driven LED pattern sequencer. Raw push buttons are synchronised,
//   edge-detected and decoded into one of five modes (restore, rotate-left,
//   rotate-right, pause, bounce). A programmable step counter paces the
//   pattern updates; the home pattern can be reloaded at run time.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   cmd[4:0]   raw buttons: [0] restore, [1] left, [2] right, [3] pause, [4] bounce
//   speed[2:0] step period = BASE_CYCLE << speed (sampled at period boundaries)
//   load_en    one-cycle strobe: load_data becomes the new home pattern
//   load_data  new home pattern
//   out        LED drive (registered)
//   mode       current mode code (0..4)
//   tick       one-cycle pulse at every step boundary (registered)
// -----------------------------------------------------------------------------
module led_pattern_engine #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  DEF_PATTERN = WIDTH'(8'b0000_0011),
  parameter int                BASE_CYCLE  = 125000000,
  parameter int                CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       cmd,
  input  logic [2:0]       speed,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       mode,
  output logic             tick
);

  typedef enum logic [2:0] {
    ST_RESTORE = 3'd0,
    ST_SHL     = 3'd1,
    ST_SHR     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_BOUNCE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           r_prev;       // mode to resume after a pause
  logic             r_dir;        // bounce direction: 0 = toward MSB, 1 = toward LSB
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_speed;      // speed captured at the last period boundary
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_home;
  logic             r_tick;
  logic [4:0]       r_sync1;
  logic [4:0]       r_sync2;
  logic [4:0]       r_sync3;      // previous synchronised value for edge detect

  logic [4:0]       w_rise;
  logic             w_accept;
  logic [CNT_W-1:0] w_period_m1;
  logic             w_last;
  state_t           w_target;
  state_t           w_next_state;
  state_t           w_next_prev;
  logic             w_clear;
  logic [WIDTH-1:0] w_bounce_out;
  logic             w_bounce_dir;

  assign w_rise      = r_sync2 & ~r_sync3;
  // Exactly one rising bit: non-zero and a power of two.
  assign w_accept    = (w_rise != 5'd0) && ((w_rise & (w_rise - 5'd1)) == 5'd0);
  assign w_period_m1 = (CNT_W'(BASE_CYCLE) << r_speed) - CNT_W'(1);
  assign w_last      = (r_cnt == w_period_m1);

  // Mode decode. Pause/resume deliberately leave the counter alone so a
  // resumed pattern finishes the interrupted period instead of restarting it.
  always_comb begin
    w_next_state = r_state;
    w_next_prev  = r_prev;
    w_clear      = 1'b0;
    w_target     = ST_RESTORE;
    if (r_state > ST_BOUNCE) begin
      w_next_state = ST_RESTORE;
      w_clear      = 1'b1;
    end else if (w_accept) begin
      if (w_rise[3]) begin
        if (r_state == ST_PAUSE) begin
          w_next_state = r_prev;
        end else if (r_state != ST_RESTORE) begin
          w_next_prev  = r_state;
          w_next_state = ST_PAUSE;
        end
      end else begin
        if (w_rise[0])      w_target = ST_RESTORE;
        else if (w_rise[1]) w_target = ST_SHL;
        else if (w_rise[2]) w_target = ST_SHR;
        else                w_target = ST_BOUNCE;
        // A press naming the current mode is a no-op (no counter clear).
        if (w_target != r_state) begin
          w_next_state = w_target;
          w_clear      = 1'b1;
        end
      end
    end
  end

  // Bounce step: turn around when the lit edge reaches the end it is heading
  // to; a pattern touching both ends (or empty) cannot move and is held.
  always_comb begin
    w_bounce_out = r_out;
    w_bounce_dir = r_dir;
    if ((r_out == '0) || (r_out[WIDTH-1] && r_out[0])) begin
      w_bounce_out = r_out;
    end else if (!r_dir) begin
      if (r_out[WIDTH-1]) begin
        w_bounce_dir = 1'b1;
        w_bounce_out = r_out >> 1;
      end else begin
        w_bounce_out = r_out << 1;
      end
    end else begin
      if (r_out[0]) begin
        w_bounce_dir = 1'b0;
        w_bounce_out = r_out << 1;
      end else begin
        w_bounce_out = r_out >> 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RESTORE;
      r_prev  <= ST_SHL;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_speed <= 3'd0;
      r_out   <= DEF_PATTERN;
      r_home  <= DEF_PATTERN;
      r_tick  <= 1'b0;
      r_sync1 <= 5'd0;
      r_sync2 <= 5'd0;
      r_sync3 <= 5'd0;
    end else begin
      r_sync1 <= cmd;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;

      if (load_en) r_home <= load_data;

      r_tick  <= w_last && (r_state != ST_PAUSE);
      r_state <= w_next_state;
      r_prev  <= w_next_prev;

      // Counter: speed is only re-sampled when a period starts afresh.
      if (w_clear) begin
        r_cnt   <= '0;
        r_speed <= speed;
      end else if (r_state != ST_PAUSE) begin
        if (w_last) begin
          r_cnt   <= '0;
          r_speed <= speed;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      case (r_state)
        // Bypass the home register so a load is visible one cycle later.
        ST_RESTORE: r_out <= load_en ? load_data : r_home;
        ST_SHL:     if (w_last) r_out <= {r_out[WIDTH-2:0], r_out[WIDTH-1]};
        ST_SHR:     if (w_last) r_out <= {r_out[0], r_out[WIDTH-1:1]};
        ST_BOUNCE: begin
          if (w_last) begin
            r_out <= w_bounce_out;
            r_dir <= w_bounce_dir;
          end
        end
        default: ;
      endcase

      if (w_clear && (w_next_state == ST_BOUNCE)) r_dir <= 1'b0;
    end
  end

  assign out  = r_out;
  assign mode = r_state;
  assign tick = r_tick;

endmodule

// File: tb/tb_led_pattern_engine.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_engine
//   Drives directed and random button/load/speed/reset traffic into
//   led_pattern_engine (WIDTH=8, BASE_CYCLE=4). A reference model evaluated at
//   every rising edge pushes the expected {out, mode, tick} into a scoreboard
//   queue; a monitor on the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_led_pattern_engine;

  localparam int BASE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] cmd = 5'd0;
  logic [2:0] speed = 3'd0;
  logic       load_en = 1'b0;
  logic [7:0] load_data = 8'd0;
  logic [7:0] out;
  logic [2:0] mode;
  logic       tick;

  int n_tests = 0;
  int n_fail  = 0;

  led_pattern_engine #(
    .WIDTH      (8),
    .DEF_PATTERN(8'h03),
    .BASE_CYCLE (BASE),
    .CNT_W      (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .speed    (speed),
    .load_en  (load_en),
    .load_data(load_data),
    .out      (out),
    .mode     (mode),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: modes as plain integers 0..4, pattern as an integer,
  // button history kept as the last three sampled cmd words.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] o;
    logic [2:0] m;
    logic       t;
  } exp_t;

  exp_t sb_q[$];

  int         m_mode, m_prev, m_dir, m_cnt, m_spd, m_out, m_home;
  int         n_mode, n_prev, n_dir, n_out, target, period;
  bit         m_tick, at_end, clear;
  logic [4:0] hist[3];
  logic [4:0] rise;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_prev = 1; m_dir = 0; m_cnt = 0; m_spd = 0;
      m_out = 8'h03; m_home = 8'h03; m_tick = 0;
      hist[0] = 5'd0; hist[1] = 5'd0; hist[2] = 5'd0;
    end else begin
      rise   = hist[1] & ~hist[2];
      period = BASE << m_spd;
      at_end = (m_cnt == period - 1);
      n_mode = m_mode; n_prev = m_prev; n_dir = m_dir; n_out = m_out;
      clear  = 0;

      if ($countones(rise) == 1) begin
        if (rise[3]) begin
          if (m_mode == 3) n_mode = m_prev;
          else if (m_mode != 0) begin
            n_prev = m_mode;
            n_mode = 3;
          end
        end else begin
          target = rise[0] ? 0 : rise[1] ? 1 : rise[2] ? 2 : 4;
          if (target != m_mode) begin
            n_mode = target;
            clear  = 1;
            if (target == 4) n_dir = 0;
          end
        end
      end

      case (m_mode)
        0: n_out = load_en ? int'(load_data) : m_home;
        1: if (at_end) n_out = ((m_out * 2) % 256) + (m_out / 128);
        2: if (at_end) n_out = (m_out / 2) + ((m_out % 2) * 128);
        4: if (at_end) begin
          if (m_out == 0 || (m_out >= 128 && m_out % 2 == 1)) n_out = m_out;
          else if (m_dir == 0) begin
            if (m_out >= 128) begin n_dir = 1; n_out = m_out / 2; end
            else n_out = m_out * 2;
          end else begin
            if (m_out % 2 == 1) begin n_dir = 0; n_out = m_out * 2; end
            else n_out = m_out / 2;
          end
        end
        default: ;
      endcase

      m_tick = at_end && (m_mode != 3);
      if (clear) begin
        m_cnt = 0; m_spd = int'(speed);
      end else if (m_mode != 3) begin
        if (at_end) begin m_cnt = 0; m_spd = int'(speed); end
        else m_cnt++;
      end

      if (load_en) m_home = int'(load_data);
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = cmd;
      m_mode = n_mode; m_prev = n_prev; m_dir = n_dir; m_out = n_out;
    end
    sb_q.push_back({8'(m_out), 3'(m_mode), m_tick});
  end

  // ---------------------------------------------------------------------------
  // Monitor: one expected entry per rising edge, compared on the falling edge.
  // ---------------------------------------------------------------------------
  bit   started = 0;
  exp_t e;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      started = 1;
      e = sb_q.pop_front();
      n_tests++;
      if (out !== e.o || mode !== e.m || tick !== e.t) begin
        n_fail++;
        $display("[TB] FAIL outputs t=%0t: out=%02h mode=%0d tick=%0b, expected out=%02h mode=%0d tick=%0b",
                 $time, out, mode, tick, e.o, e.m, e.t);
      end
    end else if (started) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard t=%0t: no expected entry, got out=%02h mode=%0d", $time, out, mode);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] bits, input int hold);
    @(negedge clk);
    cmd = bits;
    repeat (hold) @(negedge clk);
    cmd = 5'd0;
    $display("[TB] press cmd=%05b hold=%0d speed=%0d", bits, hold, speed);
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
    $display("[TB] load home=%02h", d);
  endtask

  task automatic set_speed(input logic [2:0] s);
    @(negedge clk);
    speed = s;
    $display("[TB] speed=%0d", s);
  endtask

  // Reset is raised between edges; its effect must be visible at once.
  task automatic reset_pulse();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out !== 8'h03 || mode !== 3'd0 || tick !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: out=%02h mode=%0d tick=%0b, expected out=03 mode=0 tick=0",
               out, mode, tick);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    $display("[TB] reset pulse");
  endtask

  int r;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    idle(20);

    // Left rotation, then a long hold that must not repeat.
    press(5'b00010, 3);
    idle(40);
    press(5'b00010, 40);
    idle(10);

    // Bounce through a full sweep and back.
    press(5'b10000, 3);
    idle(90);

    // All-ones home cannot bounce.
    load(8'hFF);
    press(5'b00001, 2);
    idle(5);
    press(5'b10000, 2);
    idle(30);

    // Right rotation with a pause/resume mid-period.
    load(8'h03);
    press(5'b00001, 2);
    idle(5);
    press(5'b00100, 2);
    idle(14);
    press(5'b01000, 2);
    idle(30);
    press(5'b01000, 2);
    idle(20);

    // Simultaneous rises are dropped; speed change mid-period.
    press(5'b00110, 3);
    idle(3);
    set_speed(3'd2);
    idle(50);
    set_speed(3'd0);
    idle(20);

    // Reset in the middle of a bounce.
    press(5'b10000, 2);
    idle(21);
    reset_pulse();
    idle(10);

    // Random traffic.
    for (int it = 0; it < 200; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65)      press(5'(1 << $urandom_range(0, 4)), int'($urandom_range(1, 5)));
      else if (r < 75) press(5'($urandom_range(1, 31)), int'($urandom_range(1, 4)));
      else if (r < 85) load(8'($urandom_range(0, 255)));
      else if (r < 96) set_speed(3'($urandom_range(0, 2)));
      else             reset_pulse();
      idle(int'($urandom_range(0, 20)));
    end

    idle(5);
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
